// File: rtl/uart_key_pkg.sv
// uart_key_pkg: command codes, ASCII key constants and key-to-command mapping
package uart_key_pkg;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_NONE    = 2'b00;
    localparam cmd_t CMD_FLAP    = 2'b01;
    localparam cmd_t CMD_PAUSE   = 2'b10;
    localparam cmd_t CMD_RESTART = 2'b11;

    localparam logic [7:0] KEY_SPACE = 8'h20;
    localparam logic [7:0] KEY_W_UP  = 8'h57;
    localparam logic [7:0] KEY_W_LO  = 8'h77;
    localparam logic [7:0] KEY_P_UP  = 8'h50;
    localparam logic [7:0] KEY_P_LO  = 8'h70;
    localparam logic [7:0] KEY_R_UP  = 8'h52;
    localparam logic [7:0] KEY_R_LO  = 8'h72;

    function automatic cmd_t decode_key(input logic [7:0] k);
        return (k == KEY_SPACE || k == KEY_W_UP || k == KEY_W_LO) ? CMD_FLAP :
               (k == KEY_P_UP || k == KEY_P_LO)                   ? CMD_PAUSE :
               (k == KEY_R_UP || k == KEY_R_LO)                   ? CMD_RESTART : CMD_NONE;
    endfunction

endpackage

// File: rtl/uart_key_decoder_fifo.sv
// cmd_fifo: small command queue with wrap-bit pointers and head-register read
module cmd_fifo
    import uart_key_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic wr_en,
    input  cmd_t wr_data,
    input  logic rd_en,
    output cmd_t rd_data,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr, rptr;
    cmd_t        mem [DEPTH];

    assign empty   = wptr == rptr;
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_data = mem[rptr[AW-1:0]];

    // Storage and pointer advance; the caller never writes when full without a pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= CMD_NONE;
        end else begin
            if (wr_en) begin
                mem[wptr[AW-1:0]] <= wr_data;
                wptr <= wptr + 1'b1;
            end
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_key_decoder.sv
// uart_key_decoder: sync, debounce and decode UART key bytes into queued game commands
module uart_key_decoder
    import uart_key_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    output logic       cmd_valid,
    output cmd_t       cmd_code,
    input  logic       cmd_ready,
    output logic [7:0] drop_cnt,
    output logic [7:0] bad_key_cnt
);
    logic [7:0] s1, s2, cand, last, cnt;
    logic       accept, dec_valid, full, empty, pop, wr;
    cmd_t       acc_code, dec_code;

    assign accept   = (cnt == 8'(STABLE_CYCLES - 2)) && (s2 == cand) && (cand != last);
    assign acc_code = decode_key(cand);
    assign pop      = cmd_valid && cmd_ready;
    assign wr       = dec_valid && (!full || pop);
    assign cmd_valid = !empty;

    // Two-flop synchroniser followed by a run-length stability filter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            cnt  <= '0;
            last <= '0;
        end else begin
            s1 <= rx_byte;
            s2 <= s1;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt != 8'(STABLE_CYCLES - 1)) begin
                cnt <= cnt + 1'b1;
            end
            if (accept) last <= cand;
        end
    end

    // Registered decode of each accepted byte; unmapped nonzero bytes are counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid   <= 1'b0;
            dec_code    <= CMD_NONE;
            bad_key_cnt <= '0;
        end else begin
            dec_valid <= accept && acc_code != CMD_NONE;
            dec_code  <= acc_code;
            if (accept && cand != 8'h00 && acc_code == CMD_NONE && bad_key_cnt != 8'hff)
                bad_key_cnt <= bad_key_cnt + 1'b1;
        end
    end

    // Overflow counter: a write into a full queue with no simultaneous pop is lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt <= '0;
        else if (dec_valid && full && !pop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
    end

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr),
        .wr_data(dec_code),
        .rd_en  (pop),
        .rd_data(cmd_code),
        .full   (full),
        .empty  (empty)
    );

endmodule

// File: tb/tb_uart_key_decoder.sv
// tb_uart_key_decoder: scenario tasks with a scoreboard checked on every pop
module tb_uart_key_decoder;
    import uart_key_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       cmd_valid;
    cmd_t       cmd_code;
    logic       cmd_ready = 1'b0;
    logic [7:0] drop_cnt, bad_key_cnt;

    int   tests = 0;
    int   fails = 0;
    cmd_t sb[$];

    always #5 clk = ~clk;

    uart_key_decoder #(.STABLE_CYCLES(16), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_byte    (rx_byte),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_ready  (cmd_ready),
        .drop_cnt   (drop_cnt),
        .bad_key_cnt(bad_key_cnt)
    );

    // Every handshake the DUT completes must match the oldest expected command
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got code %b, expected no command", cmd_code);
            end else begin
                cmd_t exp;
                exp = sb.pop_front();
                if (cmd_code !== exp) begin
                    fails++;
                    $display("FAIL pop_code: got %b, expected %b", cmd_code, exp);
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge
    task automatic hold(input logic [7:0] k, input int n);
        rx_byte = k;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tests++;
        if (cmd_valid !== 1'b0 || cmd_code !== CMD_NONE || drop_cnt !== 8'd0 || bad_key_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_state: valid=%b code=%b drop=%0d bad=%0d, expected 0 0 0 0",
                     cmd_valid, cmd_code, drop_cnt, bad_key_cnt);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_key;
        int lat = 0;
        cmd_ready = 1'b1;
        rx_byte = KEY_SPACE;
        sb.push_back(CMD_FLAP);
        for (int k = 1; k <= 50 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (cmd_valid) lat = k;
        end
        tests++;
        if (lat != 19) begin
            fails++;
            $display("FAIL single_latency: got edge %0d, expected 19", lat);
        end
        repeat (100 - lat) @(posedge clk);
        #1;
        hold(8'h00, 40);
        tests++;
        if (sb.size() != 0 || bad_key_cnt !== 8'd0) begin
            fails++;
            $display("FAIL single_done: pending=%0d bad=%0d, expected 0 0", sb.size(), bad_key_cnt);
        end
    endtask

    task automatic test_glitch;
        hold(KEY_W_LO, 10);
        hold(8'h00, 40);
        tests++;
        if (cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL glitch_reject: valid=%b, expected 0", cmd_valid);
        end
        sb.push_back(CMD_FLAP);
        hold(KEY_W_LO, 40);
        hold(8'h00, 40);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL glitch_followup: pending=%0d, expected 0", sb.size());
        end
    endtask

    task automatic test_key_change;
        sb.push_back(CMD_PAUSE);
        hold(KEY_P_LO, 40);
        sb.push_back(CMD_RESTART);
        hold(KEY_R_LO, 240);
        hold(8'h00, 40);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL key_change: pending=%0d, expected 0", sb.size());
        end
    endtask

    task automatic drain_check(input string name, input int n);
        cmd_ready = 1'b1;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            tests++;
            if (cmd_valid !== (i < n)) begin
                fails++;
                $display("FAIL %s_drain[%0d]: valid=%b, expected %b", name, i, cmd_valid, i < n);
            end
        end
        @(posedge clk);
        #1 cmd_ready = 1'b0;
    endtask

    task automatic test_overflow;
        cmd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) sb.push_back(CMD_FLAP);
            hold(KEY_SPACE, 40);
            hold(8'h00, 40);
        end
        tests++;
        if (drop_cnt !== 8'd2 || cmd_valid !== 1'b1) begin
            fails++;
            $display("FAIL overflow_drop: drop=%0d valid=%b, expected 2 1", drop_cnt, cmd_valid);
        end
        drain_check("overflow", 4);
    endtask

    task automatic test_bad_keys;
        hold(8'h41, 40);
        hold(8'h00, 40);
        hold(8'h41, 40);
        hold(8'h00, 40);
        tests++;
        if (bad_key_cnt !== 8'd2 || cmd_valid !== 1'b0) begin
            fails++;
            $display("FAIL bad_keys: bad=%0d valid=%b, expected 2 0", bad_key_cnt, cmd_valid);
        end
    endtask

    task automatic test_full_pop;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(CMD_FLAP);
            hold(KEY_SPACE, 40);
            hold(8'h00, 40);
        end
        sb.push_back(CMD_FLAP);
        rx_byte = KEY_SPACE;
        repeat (18) @(posedge clk);
        #1 cmd_ready = 1'b1;
        @(posedge clk);
        #1 cmd_ready = 1'b0;
        tests++;
        if (drop_cnt !== 8'd2) begin
            fails++;
            $display("FAIL full_pop_drop: drop=%0d, expected 2", drop_cnt);
        end
        repeat (21) @(posedge clk);
        #1;
        hold(8'h00, 40);
        drain_check("full_pop", 4);
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 3; i++) begin
            hold(KEY_P_UP, 40);
            hold(8'h00, 40);
        end
        tests++;
        if (cmd_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_queued: valid=%b, expected 1", cmd_valid);
        end
        rst_n = 1'b0;
        #1;
        sb.delete();
        tests++;
        if (cmd_valid !== 1'b0 || cmd_code !== CMD_NONE || drop_cnt !== 8'd0 || bad_key_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_clear: valid=%b code=%b drop=%0d bad=%0d, expected 0 0 0 0",
                     cmd_valid, cmd_code, drop_cnt, bad_key_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        begin
            int lat = 0;
            cmd_ready = 1'b1;
            rx_byte = KEY_R_UP;
            sb.push_back(CMD_RESTART);
            for (int k = 1; k <= 50 && lat == 0; k++) begin
                @(posedge clk);
                #1;
                if (cmd_valid) lat = k;
            end
            tests++;
            if (lat != 19) begin
                fails++;
                $display("FAIL reset_mid_latency: got edge %0d, expected 19", lat);
            end
        end
        hold(KEY_R_UP, 20);
        hold(8'h00, 40);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL reset_mid_restart: pending=%0d, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset;
        test_single_key;
        test_glitch;
        test_key_change;
        test_overflow;
        test_bad_keys;
        test_full_pop;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
